window3x3_gen: RTL and testbench

- Upstream stage of the approximate median filter core.
- Accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 register window.
- Presents nine taps w0..w8 with a valid strobe, wired directly to the filter's i0..i8 inputs.
- Emits a window only where all nine pixels lie inside the frame; no border padding.

---
 rtl/window3x3_gen_pkg.sv | 19 +
 rtl/window3x3_gen_line_buf.sv | 48 ++++
 rtl/window3x3_gen.sv | 137 +++++++++++++
 tb/tb_window3x3_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/window3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and the median core that
// consumes its taps. Tap ordering is row-major, oldest pixel first.
package window3x3_gen_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Tap indices: (row, col) relative to the newest pixel at bottom-right.
  localparam int unsigned W_TL     = 0;  // (r-2, c-2)
  localparam int unsigned W_TC     = 1;  // (r-2, c-1)
  localparam int unsigned W_TR     = 2;  // (r-2, c  )
  localparam int unsigned W_ML     = 3;  // (r-1, c-2)
  localparam int unsigned W_CENTRE = 4;  // (r-1, c-1)
  localparam int unsigned W_MR     = 5;  // (r-1, c  )
  localparam int unsigned W_BL     = 6;  // (r,   c-2)
  localparam int unsigned W_BC     = 7;  // (r,   c-1)
  localparam int unsigned W_BR     = 8;  // (r,   c  )
  localparam int unsigned N_TAPS   = 9;

endpackage

// File: rtl/window3x3_gen_line_buf.sv
// Enable-advanced delay line of exactly DEPTH accepted samples, built as a
// circular RAM with one wrapping pointer. The slot under the pointer is read
// before it is overwritten, so dout_o is the sample written DEPTH enables ago.
module line_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     ptr_d;

  assign dout_o = mem_q[ptr_q];

  // Next pointer: advance on enable, wrap after the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register; contents need no reset as they are never exposed unqualified.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write at the current pointer on each accepted sample.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator over a raster-order pixel stream. Two line
// buffers supply the two rows above the incoming pixel; a register window
// shifts left on every accepted pixel. A window is flagged valid only when
// all nine pixels lie inside the current frame.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8
);

  localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     pos_col;
  logic [RW-1:0]     pos_row;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] win_q [N_TAPS];
  logic [DATA_W-1:0] lb1_out;
  logic [DATA_W-1:0] lb2_out;

  // Row above the incoming pixel.
  line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH)
  ) u_lb1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (in_valid),
    .din_i  (in_data),
    .dout_o (lb1_out)
  );

  // Two rows above the incoming pixel.
  line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH)
  ) u_lb2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (in_valid),
    .din_i  (lb1_out),
    .dout_o (lb2_out)
  );

  // Position of the pixel being accepted, next counters and registered flags.
  // sof overrides the counters so this pixel is (0,0) and counting resumes at (0,1).
  always_comb begin
    pos_col     = in_sof ? '0 : col_q;
    pos_row     = in_sof ? '0 : row_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    if (in_valid) begin
      if (pos_col == COL_MAX) begin
        col_d = '0;
        row_d = (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      out_valid_d = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      out_last_d  = (pos_row == ROW_MAX) && (pos_col == COL_MAX);
    end
  end

  // Position counters and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Window shift: each row moves left, new right column from lb2/lb1/input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else if (in_valid) begin
      win_q[W_TL]     <= win_q[W_TC];
      win_q[W_TC]     <= win_q[W_TR];
      win_q[W_TR]     <= lb2_out;
      win_q[W_ML]     <= win_q[W_CENTRE];
      win_q[W_CENTRE] <= win_q[W_MR];
      win_q[W_MR]     <= lb1_out;
      win_q[W_BL]     <= win_q[W_BC];
      win_q[W_BC]     <= win_q[W_BR];
      win_q[W_BR]     <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign w0 = win_q[W_TL];
  assign w1 = win_q[W_TC];
  assign w2 = win_q[W_TR];
  assign w3 = win_q[W_ML];
  assign w4 = win_q[W_CENTRE];
  assign w5 = win_q[W_MR];
  assign w6 = win_q[W_BL];
  assign w7 = win_q[W_BC];
  assign w8 = win_q[W_BR];

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 4x4 frame. A frame-image model places each
// accepted pixel at its (row, col) and reads windows straight out of the
// image; a compare process checks every cycle, and literal windows pin the
// model for the listed scenarios.
module tb_window3x3_gen;

  localparam int unsigned DW = 8;
  localparam int W = 4;
  localparam int H = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic [9*DW-1:0] taps;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  window3x3_gen #(
    .DATA_W     (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .w0 (w0), .w1 (w1), .w2 (w2), .w3 (w3), .w4 (w4),
    .w5 (w5), .w6 (w6), .w7 (w7), .w8 (w8)
  );

  always #5 clk = ~clk;

  assign taps = {w0, w1, w2, w3, w4, w5, w6, w7, w8};

  // Reference model: an image of the current frame indexed by position.
  logic [DW-1:0]   img [H][W];
  int              mr = 0;
  int              mc = 0;
  logic            m_valid = 1'b0;
  logic            m_last  = 1'b0;
  logic [9*DW-1:0] m_w     = '0;

  always @(posedge clk) begin
    int r, c;
    if (rst) begin
      mr = 0; mc = 0; m_valid = 1'b0; m_last = 1'b0; m_w = '0;
    end else if (in_valid) begin
      r = in_sof ? 0 : mr;
      c = in_sof ? 0 : mc;
      img[r][c] = in_data;
      m_valid = (r >= 2) && (c >= 2);
      m_last  = m_valid && (r == H - 1) && (c == W - 1);
      if (m_valid)
        m_w = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
               img[r-1][c-2], img[r-1][c-1], img[r-1][c],
               img[r][c-2],   img[r][c-1],   img[r][c]};
      mc = c + 1;
      mr = r;
      if (mc == W) begin
        mc = 0;
        mr = (r == H - 1) ? 0 : r + 1;
      end
    end else begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
  end

  // Per-cycle comparison against the model; records every emitted window.
  logic [9*DW:0] log_q [$];

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (out_valid !== m_valid || out_last !== m_last) begin
        failures++;
        $display("FAIL strobes t=%0t got valid=%b last=%b want valid=%b last=%b",
                 $time, out_valid, out_last, m_valid, m_last);
      end
      if (m_valid) begin
        checks++;
        if (taps !== m_w) begin
          failures++;
          $display("FAIL taps t=%0t got %h want %h", $time, taps, m_w);
        end
      end
      if (out_valid === 1'b1) log_q.push_back({taps, out_last});
    end
  end

  task automatic chk(input string name, input logic [9*DW:0] got, input logic [9*DW:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic pix(input logic [DW-1:0] d, input logic sof, input int gap);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = DW'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input int base, input logic sof, input int max_gap);
    for (int i = 0; i < W * H; i++)
      pix(DW'(base + i), sof && (i == 0), (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0);
  endtask

  task automatic flush();
    repeat (3) @(negedge clk);
    #1;
  endtask

  localparam logic [9*DW:0] WIN_A_FIRST = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 1'b0};
  localparam logic [9*DW:0] WIN_A_LAST  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15, 1'b1};
  localparam logic [9*DW:0] WIN_B_FIRST = {8'd16, 8'd17, 8'd18, 8'd20, 8'd21, 8'd22, 8'd24, 8'd25, 8'd26, 1'b0};
  localparam logic [9*DW:0] WIN_C_FIRST = {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110, 1'b0};

  logic [9*DW:0] ref1 [$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_strobes", {72'd0, out_valid}, {72'd0, 1'b0});
    chk("reset_taps", {taps, out_last}, '0);
    armed = 1'b1;

    // Continuous frame 0..15.
    log_q.delete();
    frame(0, 1'b1, 0);
    flush();
    chk_int("s1_count", log_q.size(), 4);
    chk("s1_first", log_q[0], WIN_A_FIRST);
    chk("s1_last", log_q[3], WIN_A_LAST);
    chk_int("s1_last_flags", {log_q[0][0], log_q[1][0], log_q[2][0]}, 0);
    ref1 = log_q;

    // Same frame with random 1-3 cycle gaps.
    log_q.delete();
    frame(0, 1'b1, 3);
    flush();
    chk_int("s2_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s2_win%0d", i), log_q[i], ref1[i]);

    // Back-to-back frames.
    log_q.delete();
    frame(0, 1'b1, 0);
    frame(16, 1'b1, 0);
    flush();
    chk_int("s3_count", log_q.size(), 8);
    chk("s3_f1_last", log_q[3], WIN_A_LAST);
    chk("s3_f2_first", log_q[4], WIN_B_FIRST);

    // Aborted partial frame followed by a new sof.
    log_q.delete();
    for (int i = 0; i < 7; i++) pix(DW'(i), i == 0, 0);
    frame(100, 1'b1, 0);
    flush();
    chk_int("s4_count", log_q.size(), 4);
    chk("s4_first", log_q[0], WIN_C_FIRST);

    // Reset after pixel 9, then the frame resent without sof.
    log_q.delete();
    for (int i = 0; i < 10; i++) pix(DW'(i), i == 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s5_reset", {taps, out_valid}, '0);
    frame(0, 1'b0, 0);
    flush();
    chk_int("s5_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s5_win%0d", i), log_q[i], ref1[i]);

    // Random frames with random gaps and occasional sof.
    for (int f = 0; f < 3; f++) begin
      log_q.delete();
      for (int i = 0; i < W * H; i++)
        pix(DW'($urandom), i == 0, int'($urandom_range(0, 2)));
      flush();
      chk_int($sformatf("rand%0d_count", f), log_q.size(), (W - 2) * (H - 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
